// File: rtl/float_discriminant_feeder_if.sv
// -----------------------------------------------------------------------------
// float_discriminant_feeder_if
//
// Bundles every non-clock/reset signal of the discriminant feeder.
//   slave  : the feeder's view (coefficients and unit responses in;
//            in_rdy, issued operands, results and status out).
//   master : the surrounding environment's view (upstream producer,
//            discriminant unit and result consumer).
//
// Upstream    : in_vld, in_rdy, in_a, in_b, in_c
// Disc. unit  : disc_arg_vld, disc_a/b/c, disc_busy, disc_res_vld, disc_res,
//               disc_res_negative, disc_err
// Results     : out_vld, out_res, out_neg, out_err, out_timeout, out_tag
// Status      : busy, count (FIFO occupancy)
// -----------------------------------------------------------------------------
interface float_discriminant_feeder_if #(
  parameter int FLEN  = 64,
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_vld;
  logic             in_rdy;
  logic [FLEN-1:0]  in_a;
  logic [FLEN-1:0]  in_b;
  logic [FLEN-1:0]  in_c;

  logic             disc_arg_vld;
  logic [FLEN-1:0]  disc_a;
  logic [FLEN-1:0]  disc_b;
  logic [FLEN-1:0]  disc_c;
  logic             disc_busy;
  logic             disc_res_vld;
  logic [FLEN-1:0]  disc_res;
  logic             disc_res_negative;
  logic             disc_err;

  logic             out_vld;
  logic [FLEN-1:0]  out_res;
  logic             out_neg;
  logic             out_err;
  logic             out_timeout;
  logic [TAG_W-1:0] out_tag;

  logic             busy;
  logic [CNT_W-1:0] count;

  modport slave (
    input  in_vld, in_a, in_b, in_c,
    input  disc_busy, disc_res_vld, disc_res, disc_res_negative, disc_err,
    output in_rdy,
    output disc_arg_vld, disc_a, disc_b, disc_c,
    output out_vld, out_res, out_neg, out_err, out_timeout, out_tag,
    output busy, count
  );

  modport master (
    output in_vld, in_a, in_b, in_c,
    output disc_busy, disc_res_vld, disc_res, disc_res_negative, disc_err,
    input  in_rdy,
    input  disc_arg_vld, disc_a, disc_b, disc_c,
    input  out_vld, out_res, out_neg, out_err, out_timeout, out_tag,
    input  busy, count
  );
endinterface

// File: rtl/float_discriminant_feeder.sv
// -----------------------------------------------------------------------------
// float_discriminant_feeder
//
// Queues (a, b, c) coefficient triples in a small FIFO, tags each one with a
// running accept counter, and feeds them one at a time to an external
// discriminant unit. Exactly one triple is in flight; its result (or a
// synthesized timeout result) is presented as a registered one-cycle pulse.
//
// Ports
//   clk : clock
//   rst : synchronous, active-high reset (shared with the discriminant unit)
//   bus : float_discriminant_feeder_if.slave -- upstream handshake, issue and
//         response signals of the discriminant unit, result and status outputs
//
// Parameters
//   FLEN    : operand/result width
//   DEPTH   : FIFO entries (power of two, >= 2)
//   TAG_W   : sequence tag width
//   TIMEOUT : maximum cycles spent waiting for a result
// -----------------------------------------------------------------------------
module float_discriminant_feeder #(
  parameter int FLEN    = 64,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  float_discriminant_feeder_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [FLEN-1:0]  a;
    logic [FLEN-1:0]  b;
    logic [FLEN-1:0]  c;
  } entry_t;

  state_t           state_q;
  state_t           state_d;
  entry_t           mem [DEPTH];
  entry_t           iss_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic [TAG_W-1:0] tag_q;
  logic [TMO_W-1:0] tmo_q;

  logic             push;
  logic             pop;
  logic             arg_vld;
  logic             res_take;
  logic             tmo_hit;

  logic             out_vld_q;
  logic [FLEN-1:0]  out_res_q;
  logic             out_neg_q;
  logic             out_err_q;
  logic             out_timeout_q;
  logic [TAG_W-1:0] out_tag_q;

  // Ready depends only on registered occupancy: a pop in the same cycle does
  // not open a slot for the producer until the following cycle.
  assign bus.in_rdy = (count_q != CNT_W'(DEPTH));
  assign push       = bus.in_vld && bus.in_rdy;

  // Result events only count while a triple is actually in flight; a late
  // response arriving in IDLE after a timeout is dropped here.
  assign res_take = (state_q == WAIT) && bus.disc_res_vld;
  assign tmo_hit  = (state_q == WAIT) && !bus.disc_res_vld &&
                    (tmo_q == TMO_W'(TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if ((count_q != '0) && !bus.disc_busy) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (res_take || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pop     = 1'b0;
    arg_vld = 1'b0;
    unique case (state_q)
      IDLE:    pop     = (count_q != '0) && !bus.disc_busy;
      ISSUE:   arg_vld = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately not reset; head/tail/count alone
  // decide which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= '{tag: tag_q, a: bus.in_a, b: bus.in_b, c: bus.in_c};
  end

  // Pointers wrap naturally because DEPTH is a power of two. Because count_q
  // is registered, a triple pushed into an empty FIFO becomes poppable only
  // on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      tag_q   <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + PTR_W'(1);
        tag_q  <= tag_q + TAG_W'(1);
      end
      if (pop) head_q <= head_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Issue registers hold the operands stable from pop until the next pop.
  always_ff @(posedge clk) begin
    if (rst)      iss_q <= '0;
    else if (pop) iss_q <= mem[head_q];
  end

  // Timeout counter: cleared while issuing, advances each WAIT cycle with no
  // response. tmo_hit fires in the cycle the count would reach TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst)                                           tmo_q <= '0;
    else if (state_q == ISSUE)                         tmo_q <= '0;
    else if ((state_q == WAIT) && !bus.disc_res_vld)   tmo_q <= tmo_q + TMO_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Result registers: one-cycle pulse, payload held until the next pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q     <= 1'b0;
      out_res_q     <= '0;
      out_neg_q     <= 1'b0;
      out_err_q     <= 1'b0;
      out_timeout_q <= 1'b0;
      out_tag_q     <= '0;
    end else begin
      out_vld_q <= 1'b0;
      if (res_take) begin
        out_vld_q     <= 1'b1;
        out_res_q     <= bus.disc_res;
        out_neg_q     <= bus.disc_res_negative;
        out_err_q     <= bus.disc_err;
        out_timeout_q <= 1'b0;
        out_tag_q     <= iss_q.tag;
      end else if (tmo_hit) begin
        out_vld_q     <= 1'b1;
        out_res_q     <= '0;
        out_neg_q     <= 1'b0;
        out_err_q     <= 1'b1;
        out_timeout_q <= 1'b1;
        out_tag_q     <= iss_q.tag;
      end
    end
  end

  assign bus.disc_arg_vld = arg_vld;
  assign bus.disc_a       = iss_q.a;
  assign bus.disc_b       = iss_q.b;
  assign bus.disc_c       = iss_q.c;

  assign bus.out_vld      = out_vld_q;
  assign bus.out_res      = out_res_q;
  assign bus.out_neg      = out_neg_q;
  assign bus.out_err      = out_err_q;
  assign bus.out_timeout  = out_timeout_q;
  assign bus.out_tag      = out_tag_q;

  assign bus.busy         = (count_q != '0) || (state_q != IDLE);
  assign bus.count        = count_q;

endmodule

// File: tb/tb_float_discriminant_feeder.sv
// -----------------------------------------------------------------------------
// tb_float_discriminant_feeder
//
// Directed bench for float_discriminant_feeder. A behavioural discriminant
// unit stub answers issued operands (b*b - 4*a*c) and can be muted, held busy
// or made to deliver a stale response. Expected results are hand-computed
// IEEE-754 double constants held in vector tables.
// -----------------------------------------------------------------------------
module tb_float_discriminant_feeder;

  localparam int FLEN    = 64;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 8;
  localparam int TIMEOUT = 16;

  localparam logic [63:0] F_0   = 64'h0000_0000_0000_0000;
  localparam logic [63:0] F_1   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] F_2   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] F_4   = 64'h4010_0000_0000_0000;
  localparam logic [63:0] F_6   = 64'h4018_0000_0000_0000;
  localparam logic [63:0] F_8   = 64'h4020_0000_0000_0000;
  localparam logic [63:0] F_10  = 64'h4024_0000_0000_0000;
  localparam logic [63:0] F_12  = 64'h4028_0000_0000_0000;
  localparam logic [63:0] F_32  = 64'h4040_0000_0000_0000;
  localparam logic [63:0] F_60  = 64'h404E_0000_0000_0000;
  localparam logic [63:0] F_96  = 64'h4058_0000_0000_0000;
  localparam logic [63:0] F_M7  = 64'hC01C_0000_0000_0000;
  localparam logic [63:0] F_INF = 64'h7FF0_0000_0000_0000;

  typedef struct {
    logic [63:0] a, b, c;
    logic [63:0] res;
    logic        neg, err, tmo;
    logic [7:0]  tag;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic        neg, err, tmo;
    logic [7:0]  tag;
    int          cyc;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  float_discriminant_feeder_if #(.FLEN(FLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  float_discriminant_feeder #(
    .FLEN(FLEN), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  out_t out_q[$];
  int   acc_q[$];
  int   iss_q[$];
  int   rv_q[$];

  bit stub_mute       = 1'b0;
  bit stub_force_busy = 1'b0;
  bit stub_late       = 1'b0;

  // ---------------------------------------------------------------------------
  // Event monitor (mid-cycle sampling)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_vld && bus.in_rdy) acc_q.push_back(cyc);
      if (bus.disc_arg_vld)         iss_q.push_back(cyc);
      if (bus.disc_res_vld)         rv_q.push_back(cyc);
      if (bus.out_vld) begin
        out_t o;
        o.res = bus.out_res;
        o.neg = bus.out_neg;
        o.err = bus.out_err;
        o.tmo = bus.out_timeout;
        o.tag = bus.out_tag;
        o.cyc = cyc;
        out_q.push_back(o);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Discriminant unit stub: answers one cycle after the issue strobe, busy
  // while a request is pending. Driven shortly after the rising edge.
  // ---------------------------------------------------------------------------
  initial begin : stub
    bit          pending;
    real         ra, rb, rc, rd;
    logic [63:0] rbits;
    pending               = 1'b0;
    rd                    = 0.0;
    rbits                 = '0;
    bus.disc_busy         = 1'b0;
    bus.disc_res_vld      = 1'b0;
    bus.disc_res          = '0;
    bus.disc_res_negative = 1'b0;
    bus.disc_err          = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        pending          = 1'b0;
        bus.disc_res_vld = 1'b0;
        bus.disc_busy    = stub_force_busy;
      end else begin
        bus.disc_res_vld = 1'b0;
        if (stub_late) begin
          bus.disc_res_vld      = 1'b1;
          bus.disc_res          = F_2;
          bus.disc_res_negative = 1'b0;
          bus.disc_err          = 1'b0;
          pending               = 1'b0;
        end else if (bus.disc_arg_vld && !pending) begin
          ra      = $bitstoreal(bus.disc_a);
          rb      = $bitstoreal(bus.disc_b);
          rc      = $bitstoreal(bus.disc_c);
          rd      = rb * rb - 4.0 * ra * rc;
          rbits   = $realtobits(rd);
          pending = 1'b1;
        end else if (pending && !stub_mute) begin
          bus.disc_res_vld      = 1'b1;
          bus.disc_res          = rbits;
          bus.disc_res_negative = (rd < 0.0);
          bus.disc_err          = (rbits[62:52] == 11'h7FF);
          pending               = 1'b0;
        end
        bus.disc_busy = stub_force_busy || pending;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call aligned just after a rising edge; returns aligned likewise.
  task automatic push_triple(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    bit done;
    done       = 1'b0;
    bus.in_a   = a;
    bus.in_b   = b;
    bus.in_c   = c;
    bus.in_vld = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (bus.in_rdy) done = 1'b1;
      sync();
    end
    bus.in_vld = 1'b0;
    check("push_accepted", 64'(done), 64'(1));
  endtask

  task automatic get_out(output out_t o);
    int k;
    k = 0;
    while (out_q.size() == 0 && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("out_arrives", 64'(out_q.size() != 0), 64'(1));
    if (out_q.size() != 0) o = out_q.pop_front();
    else                   o = '{res: '0, neg: 1'b0, err: 1'b0, tmo: 1'b0, tag: '0, cyc: 0};
  endtask

  task automatic check_out(input string nm, input out_t o, input vec_t v);
    check({nm, "_res"}, o.res, v.res);
    check({nm, "_neg"}, 64'(o.neg), 64'(v.neg));
    check({nm, "_err"}, 64'(o.err), 64'(v.err));
    check({nm, "_tmo"}, 64'(o.tmo), 64'(v.tmo));
    check({nm, "_tag"}, 64'(o.tag), 64'(v.tag));
  endtask

  task automatic clear_queues();
    out_q.delete();
    acc_q.delete();
    iss_q.delete();
    rv_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Vector tables
  // ---------------------------------------------------------------------------
  vec_t vecs  [4];
  vec_t fvecs [5];

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin : main
    out_t o;
    vec_t v;

    vecs[0] = '{a: F_1, b: F_4,   c: F_2, res: F_8,   neg: 0, err: 0, tmo: 0, tag: 8'd0};
    vecs[1] = '{a: F_1, b: F_2,   c: F_1, res: F_0,   neg: 0, err: 0, tmo: 0, tag: 8'd1};
    vecs[2] = '{a: F_2, b: F_1,   c: F_1, res: F_M7,  neg: 1, err: 0, tmo: 0, tag: 8'd2};
    vecs[3] = '{a: F_1, b: F_INF, c: F_1, res: F_INF, neg: 0, err: 1, tmo: 0, tag: 8'd3};

    fvecs[0] = '{a: F_1, b: F_2,  c: F_1, res: F_0,  neg: 0, err: 0, tmo: 0, tag: 8'd4};
    fvecs[1] = '{a: F_1, b: F_4,  c: F_1, res: F_12, neg: 0, err: 0, tmo: 0, tag: 8'd5};
    fvecs[2] = '{a: F_1, b: F_6,  c: F_1, res: F_32, neg: 0, err: 0, tmo: 0, tag: 8'd6};
    fvecs[3] = '{a: F_1, b: F_8,  c: F_1, res: F_60, neg: 0, err: 0, tmo: 0, tag: 8'd7};
    fvecs[4] = '{a: F_1, b: F_10, c: F_1, res: F_96, neg: 0, err: 0, tmo: 0, tag: 8'd8};

    bus.in_vld = 1'b0;
    bus.in_a   = '0;
    bus.in_b   = '0;
    bus.in_c   = '0;

    // ---- reset state -------------------------------------------------------
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_rdy",      64'(bus.in_rdy),       64'(1));
    check("rst_busy",        64'(bus.busy),         64'(0));
    check("rst_count",       64'(bus.count),        64'(0));
    check("rst_out_vld",     64'(bus.out_vld),      64'(0));
    check("rst_arg_vld",     64'(bus.disc_arg_vld), 64'(0));
    check("rst_out_res",     bus.out_res,           64'(0));
    check("rst_out_neg",     64'(bus.out_neg),      64'(0));
    check("rst_out_err",     64'(bus.out_err),      64'(0));
    check("rst_out_timeout", 64'(bus.out_timeout),  64'(0));
    check("rst_out_tag",     64'(bus.out_tag),      64'(0));

    // ---- single triple into idle feeder ------------------------------------
    sync();
    push_triple(vecs[0].a, vecs[0].b, vecs[0].c);
    get_out(o);
    check_out("single", o, vecs[0]);
    check("single_issue_latency", 64'(iss_q[0] - acc_q[0]), 64'(2));
    check("single_out_latency",   64'(o.cyc - rv_q[0]),     64'(1));

    // ---- three back-to-back triples ----------------------------------------
    sync();
    clear_queues();
    for (int i = 1; i < 4; i++) push_triple(vecs[i].a, vecs[i].b, vecs[i].c);
    for (int i = 1; i < 4; i++) begin
      get_out(o);
      check_out($sformatf("b2b%0d", i), o, vecs[i]);
    end
    check("b2b_reissue_gap0", 64'(iss_q[1] - rv_q[0]), 64'(2));
    check("b2b_reissue_gap1", 64'(iss_q[2] - rv_q[1]), 64'(2));

    // ---- fill FIFO while the unit reports busy -----------------------------
    sync();
    clear_queues();
    stub_force_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_triple(fvecs[i].a, fvecs[i].b, fvecs[i].c);
    bus.in_a   = fvecs[4].a;
    bus.in_b   = fvecs[4].b;
    bus.in_c   = fvecs[4].c;
    bus.in_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_in_rdy", 64'(bus.in_rdy), 64'(0));
      check("full_count",  64'(bus.count),  64'(DEPTH));
    end
    check("full_no_issue", 64'(iss_q.size()), 64'(0));
    sync();
    stub_force_busy = 1'b0;
    push_triple(fvecs[4].a, fvecs[4].b, fvecs[4].c);
    check("full_accept_after_pop", 64'(acc_q[DEPTH] - iss_q[0]), 64'(0));
    for (int i = 0; i < 5; i++) begin
      get_out(o);
      check_out($sformatf("full%0d", i), o, fvecs[i]);
    end

    // ---- timeout, busy-after-timeout, stale response -----------------------
    sync();
    clear_queues();
    stub_mute = 1'b1;
    push_triple(F_1, F_4, F_2);
    get_out(o);
    v = '{a: F_1, b: F_4, c: F_2, res: F_0, neg: 0, err: 1, tmo: 1, tag: 8'd9};
    check_out("tmo", o, v);
    check("tmo_latency", 64'(o.cyc - iss_q[0]), 64'(TIMEOUT + 1));
    sync();
    push_triple(F_1, F_4, F_2);
    repeat (6) @(negedge clk);
    check("tmo_no_issue_while_busy", 64'(iss_q.size()), 64'(1));
    sync();
    stub_late = 1'b1;
    stub_mute = 1'b0;
    sync();
    stub_late = 1'b0;
    @(negedge clk);
    check("late_res_no_out_vld", 64'(bus.out_vld), 64'(0));
    #1;
    check("late_res_no_record", 64'(out_q.size()), 64'(0));
    get_out(o);
    v = '{a: F_1, b: F_4, c: F_2, res: F_8, neg: 0, err: 0, tmo: 0, tag: 8'd10};
    check_out("after_tmo", o, v);

    // ---- tag counter wrap --------------------------------------------------
    sync();
    for (int i = 0; i < 246; i++) push_triple(F_1, F_2, F_1);
    for (int i = 0; i < 246; i++) begin
      get_out(o);
      check((i == 245) ? "tag_wrap_to_0" : "tag_seq", 64'(o.tag), 64'((11 + i) % 256));
    end
    check("tag_wrap_res", o.res, F_0);

    // ---- reset while waiting with triples queued ---------------------------
    sync();
    stub_mute = 1'b1;
    for (int i = 0; i < 3; i++) push_triple(F_1, F_4, F_2);
    repeat (2) @(negedge clk);
    check("pre_rst_count", 64'(bus.count), 64'(2));
    check("pre_rst_busy",  64'(bus.busy),  64'(1));
    sync();
    rst       = 1'b1;
    stub_mute = 1'b0;
    sync();
    rst = 1'b0;
    clear_queues();
    @(negedge clk);
    check("mid_rst_count",  64'(bus.count),  64'(0));
    check("mid_rst_busy",   64'(bus.busy),   64'(0));
    check("mid_rst_in_rdy", 64'(bus.in_rdy), 64'(1));
    repeat (30) @(negedge clk);
    #1;
    check("mid_rst_no_out",   64'(out_q.size()), 64'(0));
    check("mid_rst_no_issue", 64'(iss_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/float_discriminant_feeder.md
FLOAT_DISCRIMINANT_FEEDER -- requirements
Module: float_discriminant_feeder

Interface
REQ-001 Parameter FLEN, default from config-shared.vh (64), width of FP operands and results.
REQ-002 Parameter DEPTH, default 4, coefficient FIFO entries; power of two, at least 2.
REQ-003 Parameter TAG_W, default 8, sequence tag width.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles in WAIT before timeout.
REQ-005 Clock and reset: clk is the clock; rst is the reset, synchronous, active-high.
REQ-006 Upstream input ports: in_vld (in, 1) triple valid; in_a, in_b, in_c (in, FLEN each) coefficients a, b, c.
REQ-007 Upstream output port: in_rdy (out, 1), the FIFO can accept a triple.
REQ-008 Discriminant-unit outputs: disc_arg_vld (out, 1) issue strobe; disc_a, disc_b, disc_c (out, FLEN each) issued operands.
REQ-009 Discriminant-unit inputs: disc_busy (1); disc_res_vld (1); disc_res (FLEN); disc_res_negative (1); disc_err (1).
REQ-010 Result outputs: out_vld (1) result pulse; out_res (FLEN); out_neg (1); out_err (1); out_timeout (1); out_tag (TAG_W).
REQ-011 Status outputs: busy (1); count (log2(DEPTH)+1), current FIFO occupancy.

Function
REQ-012 Accept: a triple is pushed when in_vld && in_rdy; in_rdy = (count != DEPTH) and is registered-state based, with no combinational path from in_vld.
REQ-013 Full FIFO: in_rdy=0 even if a pop happens in the same cycle; the triple is not accepted and must be held by upstream.
REQ-014 Tags: each accepted triple gets tag = accept counter value; the counter increments per accept and wraps modulo 2^TAG_W (255 -> 0 at TAG_W=8).
REQ-015 FIFO: head/tail pointers wrap modulo DEPTH; a push and a pop in the same cycle leave count unchanged.
REQ-016 Push-to-empty: a pushed triple is not visible to the pop logic until the next cycle.
REQ-017 FSM states: IDLE, ISSUE, WAIT.
REQ-018 IDLE: if count!=0 && !disc_busy, pop head into the issue registers (a, b, c, tag) -> ISSUE; otherwise stay.
REQ-019 ISSUE: disc_arg_vld=1 for exactly this one cycle; disc_a/b/c come from the issue registers and are held stable until the next pop; -> WAIT, clear the timeout counter.
REQ-020 WAIT: on disc_res_vld, capture disc_res, disc_res_negative, disc_err and the issue tag into the output registers -> IDLE.
REQ-021 WAIT: without disc_res_vld the timeout counter increments; when it reaches TIMEOUT, emit out_vld with out_res=0, out_neg=0, out_err=1, out_timeout=1 and the issue tag -> IDLE.
REQ-022 disc_res_vld seen outside WAIT (late result after a timeout) is discarded and produces no out_vld.
REQ-023 No issue while disc_busy=1: after a timeout, IDLE waits until disc_busy drops.
REQ-024 out_vld is a registered one-cycle pulse, asserted the cycle after the capturing event; out_res/out_neg/out_err/out_timeout/out_tag hold their values until the next pulse; no backpressure.
REQ-025 Latency into an empty, idle feeder with disc_busy=0: accept at cycle t -> pop at t+1 -> disc_arg_vld at t+2.
REQ-026 Latency: disc_res_vld at cycle r -> out_vld at r+1.
REQ-027 Back-to-back issue: the earliest next disc_arg_vld is r+2.
REQ-028 Ordering: results appear strictly in acceptance order (one in flight); out_tag sequence is consecutive.
REQ-029 busy = (count!=0) || (state!=IDLE).

Reset
REQ-030 On rst: state=IDLE, pointers/count=0, tag counter=0, timeout counter=0.
REQ-031 On rst: disc_arg_vld=0, out_vld=0, out_res=0, out_neg=0, out_err=0, out_timeout=0, out_tag=0, busy=0, and in_rdy=1 from the first cycle after reset.
REQ-032 Reset mid-operation discards all queued and in-flight triples, and no out_vld follows for them; the discriminant unit shares rst.

Verification
REQ-033 Single triple a=1.0, b=4.0, c=2.0 into idle -> disc_arg_vld at t+2; out_vld with out_res=8.0, out_neg=0, out_err=0, out_tag=0.
REQ-034 Three triples back-to-back: (1,2,1), (2,1,1), (1,Inf,1) -> in order: out_res=0.0 tag 0; out_res=-7.0 with out_neg=1, tag 1; out_err=1, tag 2.
REQ-035 Push DEPTH+1 triples while disc_busy is held high -> in_rdy drops after DEPTH accepts and count=DEPTH; no disc_arg_vld until disc_busy falls, then all DEPTH results arrive in order.
REQ-036 Stub unit never asserts disc_res_vld -> out_vld at ISSUE+TIMEOUT+1 with out_err=1, out_timeout=1; a later disc_res_vld is ignored.
REQ-037 256 accepted triples at TAG_W=8 -> out_tag runs 0..255 and the 257th triple gets tag 0.
REQ-038 Assert rst while in WAIT with 2 triples queued -> next cycle count=0, busy=0, in_rdy=1; no out_vld for the discarded triples.
